// File: rtl/shift_reg_pkg.sv
// Shared helpers for the serial link shift registers: frame sizing, counter sizing, even parity.
// Used by both the receive (SIPO) and transmit (PISO) sides.
package shift_reg_pkg;

  localparam int PARITY_MAX_W = 64;

  function automatic int frame_bits(input int width, input bit parity_en);
    return parity_en ? width + 1 : width;
  endfunction

  function automatic int cnt_width(input int fbits);
    return (fbits <= 2) ? 1 : $clog2(fbits);
  endfunction

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/shift_in_holding.sv
// Output holding register: loads a completed word one cycle after word_done, valid/ready handshake.
// Backpressure: a word completing while valid && !ready is dropped and sets sticky overrun.
module shift_in_holding #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_done,
  input  logic [Width-1:0] word,
  input  logic             perr,
  input  logic             ready,
  input  logic             overrun_clr,
  output logic [Width-1:0] data_out,
  output logic             valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [Width-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_perr;
  logic             w_accept;
  logic             w_drop;

  // A slot is free when empty or being drained this very cycle, which gives back-to-back with no bubble.
  assign w_accept = word_done && (!r_valid || ready);
  assign w_drop   = word_done && r_valid && !ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_accept) begin
      r_data  <= word;
      r_valid <= 1'b1;
      r_perr  <= perr;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign valid      = r_valid;
  assign overrun    = r_overrun;
  assign parity_err = r_perr;

endmodule

// File: rtl/shift_in_register.sv
// Serial-in/parallel-out receiver, LSB first; valid rises one cycle after the last frame bit.
// Optional even-parity bit per frame under SHIFT_IN_PARITY_EN; unconsumed words cause overrun.
module shift_in_register
  import shift_reg_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             enable,
  input  logic             frame_start,
  output logic [Width-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             parity_err
);

`ifdef SHIFT_IN_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int FRAME_BITS = frame_bits(Width, PAR_EN);
  localparam int CNT_W      = cnt_width(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  logic [Width-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_word_done;
  logic [Width-1:0] w_word;
  logic             w_perr;

  assign w_last      = enable && (r_cnt == LAST_CNT);
  assign w_word_done = w_last && !frame_start;

`ifdef SHIFT_IN_PARITY_EN
  // The final enable carries the parity bit; the data bits are already in sreg.
  assign w_word = r_sreg;
  assign w_perr = even_parity(PARITY_MAX_W'(r_sreg)) ^ serial_in;
`else
  assign w_word = {serial_in, r_sreg[Width-1:1]};
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
    end else if (enable) begin
      r_sreg <= {serial_in, r_sreg[Width-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (frame_start) begin
      r_cnt <= enable ? CNT_W'(1) : '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  shift_in_holding #(
    .Width(Width)
  ) u_holding (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_done  (w_word_done),
    .word       (w_word),
    .perr       (w_perr),
    .ready      (ready),
    .overrun_clr(overrun_clr),
    .data_out   (data_out),
    .valid      (valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

endmodule

// File: tb/tb_shift_in_register.sv
// Scoreboard bench for shift_in_register: directed link scenarios plus randomized traffic.
module tb_shift_in_register;

  localparam int W = 8;
`ifdef SHIFT_IN_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = PAR ? W + 1 : W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         serial_in = 1'b0;
  logic         enable = 1'b0;
  logic         frame_start = 1'b0;
  logic         ready = 1'b0;
  logic         overrun_clr = 1'b0;
  logic [W-1:0] data_out;
  logic         valid;
  logic         overrun;
  logic         parity_err;

  shift_in_register #(.Width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .serial_in  (serial_in),
    .enable     (enable),
    .frame_start(frame_start),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t         exp_q[$];
  logic         bits[$];
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_perr  = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    exp_q.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_data  = '0;
    m_perr  = 1'b0;
  endtask

  // Frame-level reference: collect bits until a full frame, then apply the holding rules.
  task automatic model_edge(input logic en, input logic b, input logic fs,
                            input logic rdy, input logic clr);
    logic done;
    logic ovr_set;
    exp_t e;
    done    = 1'b0;
    ovr_set = 1'b0;
    e       = '0;
    if (fs) begin
      bits.delete();
      if (en) bits.push_back(b);
    end else if (en) begin
      bits.push_back(b);
      if (bits.size() == FB) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) e.data[i] = bits[i];
        e.perr = PAR ? ((^e.data) ^ bits[FB-1]) : 1'b0;
        bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = e.data;
        m_perr  = e.perr;
        exp_q.push_back(e);
      end else begin
        ovr_set = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (ovr_set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
  task automatic step(input logic en, input logic b, input logic fs,
                      input logic rdy, input logic clr);
    enable      = en;
    serial_in   = b;
    frame_start = fs;
    ready       = rdy;
    overrun_clr = clr;
    @(posedge clk);
    #1;
    model_edge(en, b, fs, rdy, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_start = 1'b0;
    ready       = 1'b0;
    overrun_clr = 1'b0;
    #1;
    model_reset();
    check("reset_valid", 64'(valid), 64'(0));
    check("reset_overrun", 64'(overrun), 64'(0));
    check("reset_data_out", 64'(data_out), 64'(0));
    check("reset_parity_err", 64'(parity_err), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic pbit, input logic rdy,
                            input bit toggle, input logic clr_last);
    logic fbits[$];
    for (int i = 0; i < W; i++) fbits.push_back(w[i]);
    if (PAR) fbits.push_back(pbit);
    for (int j = 0; j < FB; j++) begin
      step(1'b1, fbits[j], 1'b0, rdy, (j == FB - 1) ? clr_last : 1'b0);
      if (toggle && j < FB - 1) step(1'b0, 1'($urandom_range(1)), 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input bit toggle);
    send_frame(w, ^w, rdy, toggle, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("valid", 64'(valid), 64'(m_valid));
      check("overrun", 64'(overrun), 64'(m_ovr));
      check("data_out", 64'(data_out), 64'(m_data));
      check("parity_err", 64'(parity_err), 64'(m_perr));
      if (valid && ready) begin
        check("consume_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("consume_data", 64'(data_out), 64'(e.data));
          check("consume_perr", 64'(parity_err), 64'(e.perr));
        end
      end
    end
  end

  initial begin
    #7;
    do_reset();

    // Basic receive 1,0,1,1,0,0,1,0 -> 8'h4D
    send_word(8'h4D, 1'b1, 1'b0);
    check("t1_valid", 64'(valid), 64'(1));
    check("t1_data", 64'(data_out), 64'h4D);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_valid_drop", 64'(valid), 64'(0));
    check("t1_data_hold", 64'(data_out), 64'h4D);

    // Back-to-back words with ready high
    send_word(8'hA5, 1'b1, 1'b0);
    check("t2_data_a5", 64'(data_out), 64'hA5);
    send_word(8'h3C, 1'b1, 1'b0);
    check("t2_data_3c", 64'(data_out), 64'h3C);
    check("t2_overrun", 64'(overrun), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overrun: second word dropped, clear on the same cycle as the drop loses to the set
    send_word(8'hFF, 1'b0, 1'b0);
    check("t3_valid", 64'(valid), 64'(1));
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_data_hold", 64'(data_out), 64'hFF);
    check("t3_overrun_set", 64'(overrun), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_overrun_clr", 64'(overrun), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_consumed", 64'(valid), 64'(0));

    // Realignment after 3 garbage bits; frame_start bit is bit 0 of 8'h81
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < W; i++) step(1'b1, (i == W - 1), 1'b0, 1'b1, 1'b0);
    if (PAR) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_valid", 64'(valid), 64'(1));
    check("t4_data", 64'(data_out), 64'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Gapped enable
    send_word(8'h5A, 1'b1, 1'b1);
    check("t5_valid", 64'(valid), 64'(1));
    check("t5_data", 64'(data_out), 64'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SHIFT_IN_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    check("p_good_perr", 64'(parity_err), 64'(0));
    check("p_good_data", 64'(data_out), 64'h07);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p_bad_perr", 64'(parity_err), 64'(1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Reset in the middle of a frame and with a word pending
    send_word(8'h96, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 1'b0);
    do_reset();
    send_word(8'hC3, 1'b1, 1'b0);
    check("rst_next_data", 64'(data_out), 64'hC3);
    check("rst_next_perr", 64'(parity_err), 64'(0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(999) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(3) != 0), 1'($urandom_range(1)), ($urandom_range(39) == 0),
             ($urandom_range(2) != 0), ($urandom_range(24) == 0));
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_in_register.md
Name: shift_in_register

Overview:
- Serial-in/parallel-out receiver; the receive-side counterpart to the team's shift-out (PISO) register on the same link.
- Samples `serial_in` LSB-first while `enable` is high and counts bits.
- After `Width` bits, transfers the assembled word into an output holding register and presents it with a valid/ready handshake.
- Flags overrun when a word completes while the previous one is still unconsumed.

Parameters:
- Width, 8, data word width in bits; legal range >= 2.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- serial_in  input  1  serial data bit, sampled when enable=1
- enable  input  1  shift strobe; one bit consumed per cycle with enable=1
- frame_start  input  1  synchronous realignment: current bit (if enable) becomes bit 0 of a new word
- data_out  output  Width  received word, LSB = first bit received
- valid  output  1  data_out holds an unconsumed word
- ready  input  1  consumer accepts data_out when valid && ready
- overrun  output  1  sticky: a completed word was dropped
- overrun_clr  input  1  synchronous clear of overrun
- parity_err  output  1  parity check result for data_out (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): shift reg=0, bit count=0, data_out=0, valid=0, overrun=0, parity_err=0.
- Shift reg `sreg[Width-1:0]`: on enable, sreg <= {serial_in, sreg[Width-1:1]}.
  - Without enable, sreg and count hold.
  - serial_in is ignored when enable=0.
- Bit counter `cnt`, width $clog2(FrameBits), where FrameBits = Width (Width+1 with parity).
  - Increments on enable.
  - Wraps to 0 on the last bit.
- Word completion: enable=1 and cnt=FrameBits-1. The completed word is {serial_in, sreg[Width-1:1]} (no parity). Next cycle:
  - If valid=0, or valid=1 && ready=1: data_out loads the word and valid=1. Valid stays high with no bubble on back-to-back completion plus consume.
  - If valid=1 && ready=0: word dropped, data_out unchanged, overrun <= 1.
- Latency: valid rises exactly one cycle after the enable cycle carrying the last bit.
- Handshake:
  - valid && ready with no completion → valid <= 0; data_out holds its last value.
  - data_out is stable while valid=1 && ready=0.
  - ready with valid=0 has no effect.
- Overrun:
  - Sticky; cleared only by overrun_clr or reset.
  - If overrun_clr and a new overrun event fall in the same cycle, set wins.
- frame_start:
  - With enable=1: the current bit is shifted in and cnt <= 1.
  - With enable=0: cnt <= 0.
  - The partial word is discarded silently: no valid, no overrun, sreg not cleared.
  - frame_start outranks completion: a word with cnt=FrameBits-1 is not emitted.
- Async reset mid-word or mid-handshake discards everything; valid drops immediately.

Optional Feature:
- Macro: SHIFT_IN_PARITY_EN.
- Defined:
  - Frame = Width data bits followed by one even-parity bit; FrameBits = Width+1.
  - Data shifts as above; the parity bit is captured on the final enable and not placed in data_out.
  - parity_err loads with data_out = XOR(data bits) ^ parity bit, and is dropped together with the word on overrun.
- Not defined: FrameBits = Width; parity_err is tied 0.

Decomposition:
- Package shift_reg_pkg:
  - function frame_bits(Width, parity_en);
  - localparam/function for counter width ($clog2 with minimum 1);
  - even-parity function, shared with a parity generator on the transmit side.
- Sub-module shift_in_holding: output holding register plus valid/ready/overrun logic.
  - Inputs: word_done, word, perr.
  - Outputs: data_out, valid, overrun, parity_err.
- Shift register and counter stay in the top.

Test Plan:
- Width=8: enable every cycle, bits 1,0,1,1,0,0,1,0 (first→last), ready=1 → valid pulses 1 cycle after the 8th bit, data_out=8'h4D, valid drops next cycle.
- Two words 8'hA5, 8'h3C back-to-back with ready=1 → valid high for both, no bubble; data_out 8'hA5 then 8'h3C; overrun=0.
- Word 8'hFF with ready=0, then full word 8'h00 → data_out stays 8'hFF, overrun=1. Then overrun_clr=1 → overrun=0 next cycle.
- frame_start with enable after 3 bits of garbage, then 7 more bits of 8'h81 → exactly one valid, data_out=8'h81.
- enable toggled 1/0 every cycle, word 8'h5A → same result as continuous enable; valid one cycle after the 8th enabled bit.
- SHIFT_IN_PARITY_EN: 8'h07 followed by parity bit 1 → parity_err=0. Repeat with parity bit 0 → parity_err=1. Assert rst_n=0 mid-frame → valid=0, next full frame decodes correctly.
